// File: rtl/spi_pwm_config_if.sv
// SPI pin bundle between an external SPI master and the PWM config front-end.
// Signals: sclk (SPI clock, mode 0), copi (data to slave, MSB first),
//          ncs (chip select, active-low). Write-only link, so there is no CIPO.
`timescale 1ns/1ps
interface spi_pwm_config_if;
   logic sclk;
   logic copi;
   logic ncs;

   modport master (output sclk, output copi, output ncs);
   modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_pwm_config.sv
// SPI-slave register front-end for the PWM peripheral.
// Receives 16-bit write frames {rw, addr[6:0], data[7:0]} (MSB first) and
// commits the data byte into one of ten 8-bit configuration registers.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   spi (slave)       sclk / copi / ncs, all asynchronous to clk
//   en_out .. pwm_gen_3_2_frequency_divider   config registers 0x00..0x09
//   wr_strobe         one-cycle pulse on a committed write
//   wr_addr           address of the last committed write
//   frame_err         one-cycle pulse on a rejected frame
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for nCS fall, bit counter held at 0
// ST_SHIFT  | shifting COPI on each SCLK rise until nCS rises
// ST_COMMIT | one cycle: validate frame, write register or flag error
`timescale 1ns/1ps
module spi_pwm_config #(
   parameter logic [6:0] MAX_ADDR    = 7'h09,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_pwm_config_if.slave      spi,
   output logic [7:0]           en_out,
   output logic [7:0]           en_pwm_out,
   output logic [7:0]           out_3_0_pwm_chanel,
   output logic [7:0]           out_7_4_pwm_chanel,
   output logic [7:0]           pwm_gen_0_duty_cycle,
   output logic [7:0]           pwm_gen_1_duty_cycle,
   output logic [7:0]           pwm_gen_2_duty_cycle,
   output logic [7:0]           pwm_gen_3_duty_cycle,
   output logic [7:0]           pwm_gen_1_0_frequency_divider,
   output logic [7:0]           pwm_gen_3_2_frequency_divider,
   output logic                 wr_strobe,
   output logic [6:0]           wr_addr,
   output logic                 frame_err
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   localparam logic [4:0] CNT_FULL = 5'd16;
   localparam logic [4:0] CNT_OVER = 5'd17;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] copi_sync;
   logic [SYNC_STAGES-1:0] ncs_sync;
   logic                   sclk_d;
   logic                   ncs_d;

   // Synchronisers reset to the idle bus levels so a reset never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         copi_sync <= '0;
         ncs_sync  <= '1;
         sclk_d    <= 1'b0;
         ncs_d     <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
         copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
         ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0],  spi.ncs};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         ncs_d     <= ncs_sync[SYNC_STAGES-1];
      end
   end

   logic sclk_s, copi_s, ncs_s;
   logic sclk_rise, ncs_fall, ncs_rise;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign copi_s    = copi_sync[SYNC_STAGES-1];
   assign ncs_s     = ncs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign ncs_fall  = ~ncs_s & ncs_d;
   assign ncs_rise  = ncs_s & ~ncs_d;

   logic [1:0]  state;
   logic [4:0]  bit_cnt;
   logic [15:0] shreg;
   logic [6:0]  frame_addr;
   logic [7:0]  frame_data;
   logic        frame_len_ok;
   logic        commit_we;
   logic        commit_err;

   assign frame_addr   = shreg[14:8];
   assign frame_data   = shreg[7:0];
   assign frame_len_ok = (bit_cnt == CNT_FULL);
   // Correct-length read frames are silently ignored; wrong length is always an error.
   assign commit_we    = (state == ST_COMMIT) && frame_len_ok && shreg[15]
                         && (frame_addr <= MAX_ADDR);
   assign commit_err   = (state == ST_COMMIT) &&
                         (!frame_len_ok || (shreg[15] && (frame_addr > MAX_ADDR)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         wr_strobe <= 1'b0;
         frame_err <= 1'b0;
         wr_addr   <= '0;
      end else begin
         wr_strobe <= commit_we;
         frame_err <= commit_err;
         if (commit_we) wr_addr <= frame_addr;
         case (state)
            ST_IDLE: begin
               bit_cnt <= '0;
               if (ncs_fall) begin
                  state <= ST_SHIFT;
                  shreg <= '0;
               end
            end
            ST_SHIFT: begin
               // An SCLK edge landing with the nCS rise belongs to no frame.
               if (ncs_rise) begin
                  state <= ST_COMMIT;
               end else if (sclk_rise) begin
                  shreg <= {shreg[14:0], copi_s};
                  if (bit_cnt != CNT_OVER) bit_cnt <= bit_cnt + 5'd1;
               end
            end
            ST_COMMIT: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_out                        <= '0;
         en_pwm_out                    <= '0;
         out_3_0_pwm_chanel            <= '0;
         out_7_4_pwm_chanel            <= '0;
         pwm_gen_0_duty_cycle          <= '0;
         pwm_gen_1_duty_cycle          <= '0;
         pwm_gen_2_duty_cycle          <= '0;
         pwm_gen_3_duty_cycle          <= '0;
         pwm_gen_1_0_frequency_divider <= '0;
         pwm_gen_3_2_frequency_divider <= '0;
      end else if (commit_we) begin
         case (frame_addr)
            7'h00:   en_out                        <= frame_data;
            7'h01:   en_pwm_out                    <= frame_data;
            7'h02:   out_3_0_pwm_chanel            <= frame_data;
            7'h03:   out_7_4_pwm_chanel            <= frame_data;
            7'h04:   pwm_gen_0_duty_cycle          <= frame_data;
            7'h05:   pwm_gen_1_duty_cycle          <= frame_data;
            7'h06:   pwm_gen_2_duty_cycle          <= frame_data;
            7'h07:   pwm_gen_3_duty_cycle          <= frame_data;
            7'h08:   pwm_gen_1_0_frequency_divider <= frame_data;
            7'h09:   pwm_gen_3_2_frequency_divider <= frame_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_pwm_config.sv
// Bench for spi_pwm_config: SPI frames driven at f_clk/8, a frame-level model
// of the register map, and a per-cycle compare of every output.
`timescale 1ns/1ps
module tb_spi_pwm_config;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_pwm_config_if spi ();

   logic [7:0] en_out, en_pwm_out, out_3_0_pwm_chanel, out_7_4_pwm_chanel;
   logic [7:0] pwm_gen_0_duty_cycle, pwm_gen_1_duty_cycle;
   logic [7:0] pwm_gen_2_duty_cycle, pwm_gen_3_duty_cycle;
   logic [7:0] pwm_gen_1_0_frequency_divider, pwm_gen_3_2_frequency_divider;
   logic       wr_strobe, frame_err;
   logic [6:0] wr_addr;

   spi_pwm_config dut (
      .clk                           (clk),
      .rst_n                         (rst_n),
      .spi                           (spi),
      .en_out                        (en_out),
      .en_pwm_out                    (en_pwm_out),
      .out_3_0_pwm_chanel            (out_3_0_pwm_chanel),
      .out_7_4_pwm_chanel            (out_7_4_pwm_chanel),
      .pwm_gen_0_duty_cycle          (pwm_gen_0_duty_cycle),
      .pwm_gen_1_duty_cycle          (pwm_gen_1_duty_cycle),
      .pwm_gen_2_duty_cycle          (pwm_gen_2_duty_cycle),
      .pwm_gen_3_duty_cycle          (pwm_gen_3_duty_cycle),
      .pwm_gen_1_0_frequency_divider (pwm_gen_1_0_frequency_divider),
      .pwm_gen_3_2_frequency_divider (pwm_gen_3_2_frequency_divider),
      .wr_strobe                     (wr_strobe),
      .wr_addr                       (wr_addr),
      .frame_err                     (frame_err)
   );

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_reg [10];
   logic [7:0] act_reg [10];
   logic       exp_strobe, exp_err;
   logic [6:0] exp_addr;
   int         strobe_seen = 0, err_seen = 0, exp_strobes = 0, exp_errs = 0;
   bit         check_on = 1'b0;

   always_comb begin
      act_reg[0] = en_out;
      act_reg[1] = en_pwm_out;
      act_reg[2] = out_3_0_pwm_chanel;
      act_reg[3] = out_7_4_pwm_chanel;
      act_reg[4] = pwm_gen_0_duty_cycle;
      act_reg[5] = pwm_gen_1_duty_cycle;
      act_reg[6] = pwm_gen_2_duty_cycle;
      act_reg[7] = pwm_gen_3_duty_cycle;
      act_reg[8] = pwm_gen_1_0_frequency_divider;
      act_reg[9] = pwm_gen_3_2_frequency_divider;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 10; i++) exp_reg[i] = 8'h00;
      exp_strobe = 1'b0;
      exp_err    = 1'b0;
      exp_addr   = 7'h00;
   endtask

   // Per-cycle compare, sampled mid-low-phase of clk.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (check_on) begin
            for (int i = 0; i < 10; i++)
               chk($sformatf("reg%0d", i), 32'(act_reg[i]), 32'(exp_reg[i]));
            chk("wr_strobe", 32'(wr_strobe), 32'(exp_strobe));
            chk("frame_err", 32'(frame_err), 32'(exp_err));
            chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
            if (wr_strobe === 1'b1) strobe_seen++;
            if (frame_err === 1'b1) err_seen++;
         end
      end
   end

   // Drives n bits (bits[n-1] first), then applies the frame rules to the model
   // exactly four clk edges after the nCS rise.
   task automatic send_frame(input logic [31:0] bits, input int n);
      logic [15:0] f;
      @(negedge clk);
      spi.ncs = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = n - 1; i >= 0; i--) begin
         spi.copi = bits[i];
         repeat (4) @(negedge clk);
         spi.sclk = 1'b1;
         repeat (4) @(negedge clk);
         spi.sclk = 1'b0;
      end
      repeat (4) @(negedge clk);
      spi.ncs = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      f = bits[15:0];
      if (n != 16) begin
         exp_err = 1'b1;
         exp_errs++;
      end else if (f[15]) begin
         if (int'(f[14:8]) > 9) begin
            exp_err = 1'b1;
            exp_errs++;
         end else begin
            exp_reg[int'(f[14:8])] = f[7:0];
            exp_addr   = f[14:8];
            exp_strobe = 1'b1;
            exp_strobes++;
         end
      end
      @(posedge clk);
      #1;
      exp_strobe = 1'b0;
      exp_err    = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, e0, n;
      logic [31:0] bits;
      spi.ncs  = 1'b1;
      spi.sclk = 1'b0;
      spi.copi = 1'b0;
      model_reset();
      check_on = 1'b1;

      // Reset held while pins toggle: everything must stay at zero.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         spi.ncs  = 1'($urandom_range(0, 1));
         spi.sclk = 1'($urandom_range(0, 1));
         spi.copi = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      spi.ncs = 1'b1; spi.sclk = 1'b0; spi.copi = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("reset_strobes", 32'(strobe_seen), 32'd0);
      chk("reset_errs", 32'(err_seen), 32'd0);

      // Single valid write.
      s0 = strobe_seen;
      send_frame(32'h8480, 16);
      chk("lit_duty0", 32'(pwm_gen_0_duty_cycle), 32'h80);
      chk("lit_wr_addr", 32'(wr_addr), 32'h04);
      chk("lit_one_strobe", 32'(strobe_seen - s0), 32'd1);
      chk("lit_en_out_untouched", 32'(en_out), 32'h00);

      // Full register map.
      s0 = strobe_seen;
      for (int a = 0; a < 10; a++)
         send_frame(32'h8000 | (32'(a) << 8) | 32'(a + 1), 16);
      chk("lit_map_strobes", 32'(strobe_seen - s0), 32'd10);
      chk("lit_map_en_out", 32'(en_out), 32'h01);
      chk("lit_map_div32", 32'(pwm_gen_3_2_frequency_divider), 32'h0A);
      chk("lit_map_duty0", 32'(pwm_gen_0_duty_cycle), 32'h05);

      // Invalid address.
      e0 = err_seen; s0 = strobe_seen;
      send_frame(32'h8AFF, 16);
      chk("lit_badaddr_err", 32'(err_seen - e0), 32'd1);
      chk("lit_badaddr_nostrobe", 32'(strobe_seen - s0), 32'd0);

      // Wrong lengths, then a zero-edge nCS glitch.
      e0 = err_seen;
      send_frame(32'h0000_4000 | 32'h55, 15);
      send_frame(32'h0001_0077, 17);
      chk("lit_len_errs", 32'(err_seen - e0), 32'd2);
      chk("lit_len_en_out", 32'(en_out), 32'h01);
      e0 = err_seen;
      send_frame(32'h0, 0);
      chk("lit_glitch_err", 32'(err_seen - e0), 32'd1);

      // Read frame: silent.
      e0 = err_seen; s0 = strobe_seen;
      send_frame(32'h0055, 16);
      chk("lit_read_err", 32'(err_seen - e0), 32'd0);
      chk("lit_read_strobe", 32'(strobe_seen - s0), 32'd0);

      // Reset after 10 bits of a write to 0x01.
      @(negedge clk);
      spi.ncs = 1'b0;
      repeat (4) @(negedge clk);
      bits = 32'h81C3;
      for (int i = 15; i >= 6; i--) begin
         spi.copi = bits[i];
         repeat (4) @(negedge clk);
         spi.sclk = 1'b1;
         repeat (4) @(negedge clk);
         spi.sclk = 1'b0;
      end
      rst_n = 1'b0;
      model_reset();
      spi.ncs = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("lit_rst_en_pwm", 32'(en_pwm_out), 32'h00);
      chk("lit_rst_en_out", 32'(en_out), 32'h00);
      send_frame(32'h8142, 16);
      chk("lit_after_rst", 32'(en_pwm_out), 32'h42);

      // Randomized frames.
      for (int k = 0; k < 80; k++) begin
         case ($urandom_range(0, 5))
            0:       n = 15;
            1:       n = 17;
            default: n = 16;
         endcase
         bits = {15'($urandom), ($urandom_range(0, 3) != 0),
                 7'($urandom_range(0, 12)), 8'($urandom)};
         if (n == 17) bits = {bits[15:0], 1'($urandom)} & 32'h1FFFF;
         send_frame(bits, n);
      end

      repeat (10) @(negedge clk);
      chk("total_strobes", 32'(strobe_seen), 32'(exp_strobes));
      chk("total_errs", 32'(err_seen), 32'(exp_errs));
      check_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
